fetch_controller: RTL

Sequences instruction fetch for the MIPS32 core. Holds the fetch PC, drives the address of the combinational 64-word instruction memory, and captures each returned word with its PC in a small instruction buffer. Presents instructions to decode over a valid/ready handshake and handles branch/jump redirects by flushing the buffer. Sits between the PC-update/execute logic and the decode stage.

---
 rtl/fetch_controller.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: fetch PC, combinational imem address, small instruction buffer
// with valid/ready handoff to decode and flush on redirect. Optional bounds check: FETCH_BOUNDS_CHECK_EN.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 64,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_data,
    input  logic                         redirect_valid,
    input  logic [31:0]                  redirect_pc,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [31:0]                  id_instr,
    output logic [31:0]                  id_pc,
    output logic [31:0]                  id_pc_plus4,
    output logic [$clog2(BUF_DEPTH):0]   buf_count,
    output logic                         fetch_fault
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef FETCH_BOUNDS_CHECK_EN
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
`endif

    state_t             state_r;
    state_t             state_nxt_s;
    logic [31:0]        fetch_pc_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [31:0]        buf_pc_r    [BUF_DEPTH];
    logic [31:0]        buf_instr_r [BUF_DEPTH];
    logic               pop_s;
    logic               push_s;
    logic               oob_s;
    logic               fault_r;

    assign pop_s = id_valid & id_ready;

    // Out-of-range detection only exists when the bounds check is compiled in
    always_comb begin
        oob_s = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
        if ((state_r == ST_RUN) && (fetch_pc_r >= MEM_BYTES)) begin
            oob_s = 1'b1;
        end else begin
            oob_s = 1'b0;
        end
`endif
    end

    // Push when running, not redirected, in range, and a slot is free or being freed
    always_comb begin
        push_s = 1'b0;
        if ((state_r == ST_RUN) && !redirect_valid && !oob_s &&
            ((count_r < CNT_W'(BUF_DEPTH)) || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Next-state logic; a redirect always lands in RUN, even from BOOT or FAULT
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_valid) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_BOOT:  state_nxt_s = ST_RUN;
`ifdef FETCH_BOUNDS_CHECK_EN
                ST_RUN:   state_nxt_s = oob_s ? ST_FAULT : ST_RUN;
                ST_FAULT: state_nxt_s = ST_FAULT;
`else
                ST_RUN:   state_nxt_s = ST_RUN;
`endif
                default:  state_nxt_s = ST_BOOT;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Fetch PC, occupancy and pointers; redirect flushes and retargets
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_r <= RESET_PC;
            count_r    <= {CNT_W{1'b0}};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
        end else if (redirect_valid) begin
            fetch_pc_r <= {redirect_pc[31:2], 2'b00};
            count_r    <= {CNT_W{1'b0}};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                fetch_pc_r <= fetch_pc_r + 32'd4;
                tail_r     <= tail_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Buffer storage; cleared on reset so the head reads zero before the first push
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc_r[i]    <= 32'd0;
                buf_instr_r[i] <= 32'd0;
            end
        end else if (push_s) begin
            buf_pc_r[tail_r]    <= fetch_pc_r;
            buf_instr_r[tail_r] <= imem_data;
        end
    end

`ifdef FETCH_BOUNDS_CHECK_EN
    // Sticky fault flag, cleared only by a redirect or reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault_r <= 1'b0;
        end else if (redirect_valid) begin
            fault_r <= 1'b0;
        end else if (oob_s) begin
            fault_r <= 1'b1;
        end
    end
`else
    assign fault_r = 1'b0;
`endif

    assign imem_addr   = fetch_pc_r;
    assign buf_count   = count_r;
    assign id_valid    = (count_r != {CNT_W{1'b0}});
    assign id_instr    = buf_instr_r[head_r];
    assign id_pc       = buf_pc_r[head_r];
    assign id_pc_plus4 = buf_pc_r[head_r] + 32'd4;
    assign fetch_fault = fault_r;

endmodule
